// File: rtl/ase_tid_tagger.sv
// ase_tid_tagger: stamps each CCI-P TX request with a transaction ID, buffers
// it in a small FIFO and releases the head only while the outstanding-line
// credit budget can absorb its cost. Response lines return credits.
//
// Header layout (CCIP_TX_HDR_WIDTH bits):
//   [3:0] reqtype   [5:4] len (cache lines - 1)   [W-1:6] opaque payload
// Request type codes:
//   0 RDLINE_I, 1 RDLINE_S, 2 WRLINE_I, 3 WRLINE_M, 4 WRPUSH_I, 5 WRFENCE
// Codes that are neither a read nor a fence are charged as writes.
module ase_tid_tagger #(
  parameter int TID_WIDTH         = 32,
  parameter int FIFO_DEPTH_BASE2  = 3,
  parameter int MAX_OUTSTANDING   = 64,
  parameter int CCIP_TX_HDR_WIDTH = 16,
  localparam int CNT_W            = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic [CCIP_TX_HDR_WIDTH-1:0] hdr_in,
  output logic                         almfull_out,
  output logic                         valid_out,
  output logic [CCIP_TX_HDR_WIDTH-1:0] hdr_out,
  output logic [TID_WIDTH-1:0]         tid_out,
  input  logic                         ready_in,
  input  logic                         rsp_valid,
  output logic [CNT_W-1:0]             outstanding_cnt,
  output logic                         overflow_err,
  output logic                         underflow_err
);

  localparam int DEPTH = 1 << FIFO_DEPTH_BASE2;
  localparam int PW    = FIFO_DEPTH_BASE2 + 1;
  localparam int SUM_W = CNT_W + 3;

  localparam logic [3:0] REQ_RDLINE_I = 4'h0;
  localparam logic [3:0] REQ_RDLINE_S = 4'h1;
  localparam logic [3:0] REQ_WRFENCE  = 4'h5;

  localparam logic [PW-1:0]    ALMFULL_LVL = PW'(DEPTH - 2);
  localparam logic [SUM_W-1:0] CREDIT_MAX  = SUM_W'(MAX_OUTSTANDING);

  // Credit cost of a request: reads cost their line count, fences are free.
  function automatic logic [2:0] req_cost(input logic [3:0] rtype,
                                          input logic [1:0] len);
    case (rtype)
      REQ_RDLINE_I, REQ_RDLINE_S: req_cost = {1'b0, len} + 3'd1;
      REQ_WRFENCE:                req_cost = 3'd0;
      default:                    req_cost = 3'd1;
    endcase
  endfunction

  logic [CCIP_TX_HDR_WIDTH-1:0] hdr_mem [DEPTH];
  logic [TID_WIDTH-1:0]         tid_mem [DEPTH];

  logic [PW-1:0]          wr_ptr, rd_ptr, count;
  logic [TID_WIDTH-1:0]   tid_ctr;
  logic                   empty, full, push, pop;
  logic [2:0]             head_cost;
  logic [SUM_W-1:0]       head_need;
  logic [SUM_W-1:0]       cnt_sum;
  logic [CNT_W-1:0]       cnt_nxt;
  logic                   underflow_set;

  // Occupancy: extra pointer MSB separates full from empty.
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                 (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);

  assign almfull_out = (count >= ALMFULL_LVL);

  assign hdr_out   = hdr_mem[rd_ptr[PW-2:0]];
  assign tid_out   = tid_mem[rd_ptr[PW-2:0]];
  assign head_cost = req_cost(hdr_out[3:0], hdr_out[5:4]);
  assign head_need = SUM_W'(outstanding_cnt) + SUM_W'(head_cost);

  // The head waits until the credit budget can take its whole cost.
  assign valid_out = !empty && (head_need <= CREDIT_MAX);

  // A request arriving while full is dropped even if the head leaves now.
  assign push = valid_in && !full;
  assign pop  = valid_out && ready_in;

  // Credit counter: add the popped cost, then retire one response line.
  always_comb begin
    cnt_sum       = SUM_W'(outstanding_cnt) + (pop ? SUM_W'(head_cost) : '0);
    underflow_set = 1'b0;
    if (rsp_valid) begin
      if (cnt_sum == '0) underflow_set = 1'b1;
      else               cnt_sum = cnt_sum - SUM_W'(1);
    end
    cnt_nxt = CNT_W'(cnt_sum);
  end

  // FIFO storage: entry carries the header and the ID it was stamped with.
  always_ff @(posedge clk) begin
    if (push) begin
      hdr_mem[wr_ptr[PW-2:0]] <= hdr_in;
      tid_mem[wr_ptr[PW-2:0]] <= tid_ctr;
    end
  end

  // Control state: pointers, ID counter, credit counter, sticky errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      tid_ctr         <= '0;
      outstanding_cnt <= '0;
      overflow_err    <= 1'b0;
      underflow_err   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + PW'(1);
        tid_ctr <= tid_ctr + TID_WIDTH'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (valid_in && full) overflow_err <= 1'b1;
      if (underflow_set) underflow_err <= 1'b1;
      outstanding_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_ase_tid_tagger.sv
// Bench for ase_tid_tagger: instance A (default parameters) is checked every
// cycle against a queue-based reference model under directed and random
// traffic; instance B (4 credits, 4-bit TIDs) covers credit stalls, zero-cost
// fences at the credit limit and TID wrap with directed expectations.
module tb_ase_tid_tagger;

  localparam logic [3:0] T_RDI = 4'h0, T_RDS = 4'h1, T_WRI = 4'h2,
                         T_WRM = 4'h3, T_WRP = 4'h4, T_FNC = 4'h5;
  localparam int A_MAX = 64;
  localparam int A_DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals
  logic        a_rst = 1'b1, a_valid = 1'b0, a_rdy = 1'b0, a_rsp = 1'b0;
  logic [15:0] a_hdr = '0, a_hout;
  logic [31:0] a_tout;
  logic [6:0]  a_cnt;
  logic        a_almfull, a_vout, a_ovf, a_unf;

  // Instance B signals
  logic        b_rst = 1'b1, b_valid = 1'b0, b_rdy = 1'b0, b_rsp = 1'b0;
  logic [15:0] b_hdr = '0, b_hout;
  logic [3:0]  b_tout;
  logic [2:0]  b_cnt;
  logic        b_almfull, b_vout, b_ovf, b_unf;

  ase_tid_tagger dut_a (
    .clk(clk), .rst(a_rst), .valid_in(a_valid), .hdr_in(a_hdr),
    .almfull_out(a_almfull), .valid_out(a_vout), .hdr_out(a_hout),
    .tid_out(a_tout), .ready_in(a_rdy), .rsp_valid(a_rsp),
    .outstanding_cnt(a_cnt), .overflow_err(a_ovf), .underflow_err(a_unf)
  );

  ase_tid_tagger #(.TID_WIDTH(4), .MAX_OUTSTANDING(4)) dut_b (
    .clk(clk), .rst(b_rst), .valid_in(b_valid), .hdr_in(b_hdr),
    .almfull_out(b_almfull), .valid_out(b_vout), .hdr_out(b_hout),
    .tid_out(b_tout), .ready_in(b_rdy), .rsp_valid(b_rsp),
    .outstanding_cnt(b_cnt), .overflow_err(b_ovf), .underflow_err(b_unf)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [3:0] t, input logic [1:0] len,
                                     input logic [9:0] tag);
    mk = {tag, len, t};
  endfunction

  // Reference model for instance A
  typedef struct packed {
    logic [15:0] hdr;
    logic [31:0] tid;
  } ent_t;

  ent_t        mq[$];
  int          mcnt = 0;
  logic [31:0] mtid = '0;
  logic        movf = 1'b0, munf = 1'b0;

  function automatic int mcost(input logic [15:0] h);
    if (h[3:0] == T_RDI || h[3:0] == T_RDS) mcost = int'(h[5:4]) + 1;
    else if (h[3:0] == T_FNC)               mcost = 0;
    else                                    mcost = 1;
  endfunction

  task automatic a_reset();
    a_rst = 1'b1; a_valid = 1'b1; a_rdy = 1'b1; a_rsp = 1'b1;
    a_hdr = mk(T_WRI, 2'd0, 10'h3ff);
    @(posedge clk); #1;
    a_rst = 1'b0; a_valid = 1'b0; a_rdy = 1'b0; a_rsp = 1'b0;
    mq.delete(); mcnt = 0; mtid = '0; movf = 1'b0; munf = 1'b0;
  endtask

  // One cycle on A: check combinational outputs, advance model, check state.
  task automatic a_cycle(input logic v, input logic [15:0] h, input logic r,
                         input logic rsp);
    ent_t e;
    int   c, tmp;
    bit   mv, pop, accept;
    a_valid = v; a_hdr = h; a_rdy = r; a_rsp = rsp;
    #1;
    mv = (mq.size() > 0) && (mcnt + mcost(mq[0].hdr) <= A_MAX);
    chk("a_valid_out", a_vout, mv);
    chk("a_almfull", a_almfull, mq.size() >= A_DEPTH - 2);
    if (mq.size() > 0) begin
      chk("a_head_tid", a_tout, mq[0].tid);
      chk("a_head_hdr", a_hout, mq[0].hdr);
    end
    pop    = mv && r;
    c      = pop ? mcost(mq[0].hdr) : 0;
    accept = v && (mq.size() < A_DEPTH);
    if (v && !accept) movf = 1'b1;
    if (pop) e = mq.pop_front();
    if (accept) begin
      e.hdr = h; e.tid = mtid;
      mq.push_back(e);
      mtid = mtid + 32'd1;
    end
    tmp = mcnt + c;
    if (rsp) begin
      if (tmp == 0) munf = 1'b1;
      else          tmp = tmp - 1;
    end
    mcnt = tmp;
    @(posedge clk); #1;
    chk("a_outstanding", a_cnt, mcnt);
    chk("a_overflow", a_ovf, movf);
    chk("a_underflow", a_unf, munf);
  endtask

  task automatic b_cycle(input logic v, input logic [15:0] h, input logic r,
                         input logic rsp);
    b_valid = v; b_hdr = h; b_rdy = r; b_rsp = rsp;
    @(posedge clk); #1;
    b_valid = 1'b0; b_rdy = 1'b0; b_rsp = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] wr, fnc;
    wr  = mk(T_WRI, 2'd0, 10'h055);
    fnc = mk(T_FNC, 2'd0, 10'h0aa);

    @(posedge clk); #1;
    b_rst = 1'b0;
    a_reset();
    chk("rst_valid_out", a_vout, 1'b0);
    chk("rst_almfull", a_almfull, 1'b0);
    chk("rst_outstanding", a_cnt, 7'd0);
    chk("rst_overflow", a_ovf, 1'b0);
    chk("rst_underflow", a_unf, 1'b0);

    // Three back-to-back writes with ready high
    a_cycle(1'b1, wr, 1'b1, 1'b0);
    chk("t1_tid0", a_tout, 32'd0);
    a_cycle(1'b1, wr, 1'b1, 1'b0);
    chk("t1_tid1", a_tout, 32'd1);
    a_cycle(1'b1, wr, 1'b1, 1'b0);
    chk("t1_tid2", a_tout, 32'd2);
    a_cycle(1'b0, '0, 1'b1, 1'b0);
    chk("t1_cnt3", a_cnt, 7'd3);
    chk("t1_empty", a_vout, 1'b0);

    // Fill with ready low: 8 accepted, then overflow
    a_reset();
    for (int i = 0; i < 10; i++) begin
      a_cycle(1'b1, mk(T_WRM, 2'd0, 10'(i)), 1'b0, 1'b0);
      if (i == 4) chk("t2_af_occ5", a_almfull, 1'b0);
      if (i == 5) chk("t2_af_occ6", a_almfull, 1'b1);
      if (i == 7) chk("t2_no_ovf8", a_ovf, 1'b0);
      if (i == 8) chk("t2_ovf9", a_ovf, 1'b1);
    end
    a_cycle(1'b1, wr, 1'b1, 1'b0);   // pop while full: request still dropped
    for (int i = 0; i < 7; i++) a_cycle(1'b0, '0, 1'b1, 1'b0);
    a_cycle(1'b1, wr, 1'b0, 1'b0);
    chk("t2_next_tid8", a_tout, 32'd8);

    // Fence between two writes
    a_reset();
    a_cycle(1'b1, wr, 1'b0, 1'b0);
    a_cycle(1'b1, fnc, 1'b0, 1'b0);
    a_cycle(1'b1, wr, 1'b0, 1'b0);
    chk("t3_tid0", a_tout, 32'd0);
    a_cycle(1'b0, '0, 1'b1, 1'b0);
    chk("t3_tid1", a_tout, 32'd1);
    a_cycle(1'b0, '0, 1'b1, 1'b0);
    chk("t3_tid2", a_tout, 32'd2);
    a_cycle(1'b0, '0, 1'b1, 1'b0);
    chk("t3_cnt2", a_cnt, 7'd2);

    // Underflow, and rsp alongside a pop from zero
    a_reset();
    a_cycle(1'b0, '0, 1'b0, 1'b1);
    chk("t4_unf_set", a_unf, 1'b1);
    chk("t4_unf_cnt0", a_cnt, 7'd0);
    a_reset();
    a_cycle(1'b1, wr, 1'b0, 1'b0);
    a_cycle(1'b0, '0, 1'b1, 1'b1);
    chk("t4_pop_rsp_cnt", a_cnt, 7'd0);
    chk("t4_pop_rsp_noerr", a_unf, 1'b0);

    // Reset mid-stream with five entries queued
    a_reset();
    for (int i = 0; i < 3; i++) a_cycle(1'b1, wr, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) a_cycle(1'b1, mk(T_RDS, 2'd1, 10'(i)), 1'b0, 1'b0);
    a_reset();
    chk("t6_rst_vout", a_vout, 1'b0);
    chk("t6_rst_cnt", a_cnt, 7'd0);
    chk("t6_rst_af", a_almfull, 1'b0);
    a_cycle(1'b1, wr, 1'b0, 1'b0);
    chk("t6_rst_tid0", a_tout, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) == 0) begin
        a_reset();
      end else begin
        a_cycle(($urandom_range(9) < 6),
                mk(4'($urandom_range(5)), 2'($urandom_range(3)), 10'($urandom)),
                ($urandom_range(9) < 6), ($urandom_range(9) < 4));
      end
    end

    // Instance B: 4 credits, 4-bit TIDs
    b_rst = 1'b1; b_cycle(1'b0, '0, 1'b0, 1'b0); b_rst = 1'b0;
    chk("b_rst_vout", b_vout, 1'b0);
    chk("b_rst_cnt", b_cnt, 3'd0);
    b_cycle(1'b1, mk(T_RDI, 2'd3, 10'h001), 1'b0, 1'b0);
    b_cycle(1'b1, wr, 1'b0, 1'b0);
    chk("b_rd_ready", b_vout, 1'b1);
    chk("b_rd_tid", b_tout, 4'd0);
    b_cycle(1'b0, '0, 1'b1, 1'b0);
    chk("b_rd_cnt4", b_cnt, 3'd4);
    chk("b_wr_held", b_vout, 1'b0);
    chk("b_wr_tid", b_tout, 4'd1);
    b_cycle(1'b0, '0, 1'b1, 1'b1);
    chk("b_rsp_cnt3", b_cnt, 3'd3);
    chk("b_wr_released", b_vout, 1'b1);
    b_cycle(1'b0, '0, 1'b1, 1'b0);
    chk("b_wr_cnt4", b_cnt, 3'd4);
    chk("b_empty", b_vout, 1'b0);
    b_cycle(1'b1, fnc, 1'b0, 1'b0);
    chk("b_fence_at_max", b_vout, 1'b1);
    chk("b_fence_tid", b_tout, 4'd2);
    b_cycle(1'b0, '0, 1'b1, 1'b0);
    chk("b_fence_cnt", b_cnt, 3'd4);
    chk("b_fence_gone", b_vout, 1'b0);
    for (int i = 0; i < 12; i++) b_cycle(1'b1, fnc, 1'b1, 1'b0);
    b_cycle(1'b1, fnc, 1'b0, 1'b0);
    b_cycle(1'b1, fnc, 1'b0, 1'b0);
    chk("b_tid14", b_tout, 4'd14);
    b_cycle(1'b0, '0, 1'b1, 1'b0);
    chk("b_tid15", b_tout, 4'd15);
    b_cycle(1'b0, '0, 1'b1, 1'b0);
    chk("b_tid_wrap0", b_tout, 4'd0);
    chk("b_final_cnt", b_cnt, 3'd4);
    chk("b_no_ovf", b_ovf, 1'b0);
    chk("b_no_unf", b_unf, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ase_tid_tagger.md
# ase_tid_tagger

Request-side front stage for the ASE transaction checker path. Accepts CCI-P TX requests, stamps each with a monotonically increasing transaction ID, buffers them in a small FIFO, and releases them downstream only while a line-credit budget allows. The released `valid_out`/`hdr_out`/`tid_out` stream is exactly what the downstream stream checker consumes as its `valid_in`/`hdr_in`/`tid_in`. Per-line response returns free credits.

## Interface
- `TID_WIDTH`, 32: transaction ID width.
- `FIFO_DEPTH_BASE2`, 3: FIFO depth = 2^FIFO_DEPTH_BASE2 entries (default 8).
- `MAX_OUTSTANDING`, 64: maximum outstanding response lines.
- `clk`  in  1: single clock; all state updates on posedge.
- `rst`  in  1: synchronous, active-high reset.
- `valid_in`  in  1: request strobe.
- `hdr_in`  in  TxHdr_t (CCIP_TX_HDR_WIDTH): request header (`reqtype`, `len`).
- `almfull_out`  out  1: FIFO occupancy >= DEPTH-2.
- `valid_out`  out  1: head entry is presentable downstream.
- `hdr_out`  out  TxHdr_t: head header.
- `tid_out`  out  TID_WIDTH: head TID.
- `ready_in`  in  1: downstream accepts the head this cycle.
- `rsp_valid`  in  1: one response line returned; frees one credit.
- `outstanding_cnt`  out  $clog2(MAX_OUTSTANDING+1): credits in use.
- `overflow_err`  out  1: sticky; request dropped because the FIFO was full.
- `underflow_err`  out  1: sticky; response with no outstanding credit.

## Operation
- Cost of a request: CCIP_RDLINE_I / CCIP_RDLINE_S = `len`+1 (1..4); write types = 1; CCIP_WRFENCE = 0.
- Enqueue: `valid_in` and count < DEPTH, where count is the pre-pop occupancy. The entry written is {hdr_in, tid_ctr}. `tid_ctr` then increments, fences included.
- Drop: `valid_in` and count == DEPTH. Entry discarded, `tid_ctr` unchanged, `overflow_err` set. This applies even if a pop occurs in the same cycle.
- `tid_ctr` wraps from 2^TID_WIDTH-1 to 0 with no flag.
- `valid_out` = FIFO non-empty AND (`outstanding_cnt` + cost(head) <= MAX_OUTSTANDING).
- `hdr_out`/`tid_out` always show the head entry. They are don't-care when the FIFO is empty.
- Pop/transfer: `valid_out` && `ready_in`. The pop adds cost(head) to the counter.
- Head-of-line blocking: a head lacking credit stalls all entries behind it. No reordering.
- Counter update: next = cur + (pop ? cost(head) : 0) - (rsp_valid ? 1 : 0).
  - Simultaneous pop and rsp_valid are both applied in the same cycle.
  - If cur == 0, no pop, and rsp_valid: the counter stays 0 and `underflow_err` is set.
  - If cur == 0 and a pop and rsp_valid occur together: net update applied, no error.
- Errors clear only on `rst`.
- FIFO pointers are FIFO_DEPTH_BASE2+1 bits. Full and empty are distinguished by the MSB. Pointers wrap naturally.

## Timing
- Reset (synchronous, on the `rst`-high clock edge):
  - pointers = 0, `tid_ctr` = 0, `outstanding_cnt` = 0.
  - `valid_out` = 0, `almfull_out` = 0, `overflow_err` = 0, `underflow_err` = 0.
  - Buffered entries are discarded.
  - `valid_in`, `rsp_valid`, and `ready_in` are ignored while `rst` is high.
- Latency: a request enqueued at edge N is visible on `valid_out` after edge N; earliest transfer is in cycle N+1. There is no same-cycle bypass.
- `valid_out`, `almfull_out`, and the head fields are combinational from registered state.
- Simultaneous enqueue and pop at count == DEPTH-1 or lower: occupancy unchanged, data order preserved.
- Sustained throughput is one request per cycle while credit permits.
- `almfull_out` asserts the cycle after occupancy reaches DEPTH-2. Upstream must stop within 2 requests.

## Test plan
- Reset then 3 writes on consecutive cycles, `ready_in`=1. Required: `tid_out` 0, 1, 2 on cycles 1, 2, 3; `outstanding_cnt` = 3 after the third transfer.
- `ready_in`=0, 10 requests. Required: 8 accepted; `almfull_out` high from occupancy 6; `overflow_err`=1 at the 9th request; next accepted request later receives tid 8.
- MAX_OUTSTANDING=4: RDLINE_I len=3 then a write. Required: read transfers and `outstanding_cnt`=4; write held with `valid_out`=0; one `rsp_valid` makes `valid_out`=1; after the write transfers, `outstanding_cnt`=4.
- Fence between two writes. Required: tids 0, 1, 2; fence transfers with zero cost even while `outstanding_cnt`==MAX_OUTSTANDING.
- `rsp_valid` with `outstanding_cnt`=0. Required: `underflow_err`=1, counter 0. Same cycle as a write pop from 0: counter 0, no error.
- Preload `tid_ctr` to 2^32-1 (force). Required: two requests get tids FFFFFFFF then 00000000. Asserting `rst` mid-stream with 5 entries queued: `valid_out`=0 and all counters 0 on the next cycle.
